// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline control unit.
// Optional performance counters are enabled with the PIPE_CTRL_PERF_EN macro.
package pipe_pkg;

    localparam int DEF_STAGES = 5;
    localparam int DEF_EXT_W  = 4;
    localparam int DEF_CNT_W  = 32;

    localparam int STG_F = 4;
    localparam int STG_D = 3;
    localparam int STG_E = 2;
    localparam int STG_M = 1;
    localparam int STG_W = 0;

    // Saturating increment for any counter up to 64 bits wide.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage

// File: rtl/pipe_ext_cnt.sv
// Per-stage multi-cycle extend counter: qualifies extend pulses and
// counts down the remaining extra cycles of the stage.
module pipe_ext_cnt
    import pipe_pkg::*;
#(
    parameter int EXT_W = DEF_EXT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             extend,
    input  logic             valid,
    input  logic             flush,
    input  logic [EXT_W-1:0] len,
    output logic             hit,
    output logic             busy
);

    logic [EXT_W-1:0] ec;

    assign busy = (ec != '0);
    // A running counter, zero length or a bubble stage make the pulse a no-op.
    assign hit  = extend & valid & (len != '0) & ~busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ec <= '0;
        end else if (flush) begin
            ec <= '0;
        end else if (hit) begin
            ec <= len - EXT_W'(1);
        end else if (busy) begin
            ec <= ec - EXT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// N-stage in-order pipeline control: stall/extend/flush to keep and dirty.
// Define PIPE_CTRL_PERF_EN to build the saturating performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES = DEF_STAGES,
    parameter int EXT_W  = DEF_EXT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    input  logic [STAGES-1:0]       extend,
    input  logic [STAGES*EXT_W-1:0] ext_len,
    output logic [STAGES-1:0]       keep,
    output logic [STAGES-1:0]       dirty,
    output logic [STAGES-1:0]       busy,
    input  logic                    perf_clr,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt,
    output logic [CNT_W-1:0]        bubble_cnt
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_nxt;
    logic [STAGES-1:0] hit;
    logic [STAGES-1:0] h;
    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] up_hold;

    for (genvar g = 0; g < STAGES; g++) begin : g_ext
        pipe_ext_cnt #(.EXT_W(EXT_W)) u_ext (
            .clk    (clk),
            .rst    (rst),
            .extend (extend[g]),
            .valid  (v[g]),
            .flush  (flush[g]),
            .len    (ext_len[g*EXT_W +: EXT_W]),
            .hit    (hit[g]),
            .busy   (busy[g])
        );
    end

    assign h = stall | hit | busy;

    // A hold anywhere downstream (lower index) backs up every upstream stage.
    always_comb begin
        logic acc;
        hold = '0;
        acc  = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            acc     = acc | h[i];
            hold[i] = acc;
        end
    end

    // Fetch always has a fresh instruction behind it and is never held from above.
    assign up_v    = {1'b1, v[STAGES-1:1]};
    assign up_hold = {1'b0, hold[STAGES-1:1]};

    always_comb begin
        v_nxt = v;
        for (int i = 0; i < STAGES; i++) begin
            if (flush[i]) begin
                v_nxt[i] = 1'b0;
            end else if (hold[i]) begin
                v_nxt[i] = v[i];
            end else if (up_hold[i]) begin
                v_nxt[i] = 1'b0;
            end else begin
                v_nxt[i] = up_v[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
        end else begin
            v <= v_nxt;
        end
    end

    assign keep  = hold;
    assign dirty = ~v;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] bubble_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            flush_q  <= '0;
            bubble_q <= '0;
        end else if (perf_clr) begin
            stall_q  <= '0;
            flush_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (keep[STAGES-1]) stall_q  <= CNT_W'(sat_inc(64'(stall_q), CNT_W));
            if (|flush)         flush_q  <= CNT_W'(sat_inc(64'(flush_q), CNT_W));
            if (dirty[0])       bubble_q <= CNT_W'(sat_inc(64'(bubble_q), CNT_W));
        end
    end

    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign bubble_cnt = bubble_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (STAGES=5, EXT_W=4, CNT_W=4) with a scoreboard queue.
module tb_pipe_ctrl;

    localparam int W = 27;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [W-1:0] M_NOCNT = {{15{1'b1}}, {12{1'b0}}};

    logic        clk;
    logic        rst;
    logic [4:0]  stall, flush, extend;
    logic [19:0] ext_len;
    logic [4:0]  keep, dirty, busy;
    logic        perf_clr;
    logic [3:0]  stall_cnt, flush_cnt, bubble_cnt;

    pipe_ctrl #(.STAGES(5), .EXT_W(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .extend     (extend),
        .ext_len    (ext_len),
        .keep       (keep),
        .dirty      (dirty),
        .busy       (busy),
        .perf_clr   (perf_clr),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .bubble_cnt (bubble_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    int           tag_q[$];
    int           checks = 0;
    int           errors = 0;
    int           step_no = 0;

    // driver: drive one cycle of inputs and queue the response expected that cycle
    task automatic step(input logic r, input logic [4:0] st, input logic [4:0] fl,
                        input logic [4:0] ex, input logic [19:0] len, input logic pc,
                        input logic [4:0] k, input logic [4:0] d, input logic [4:0] b,
                        input logic [3:0] sc, input logic [3:0] fc, input logic [3:0] bc,
                        input logic cc);
        @(posedge clk);
        #1;
        rst      = r;
        stall    = st;
        flush    = fl;
        extend   = ex;
        ext_len  = len;
        perf_clr = pc;
        exp_q.push_back({k, d, b, sc, fc, bc});
        msk_q.push_back(cc ? {W{1'b1}} : M_NOCNT);
        tag_q.push_back(step_no);
        step_no++;
    endtask

    task automatic s(input logic [4:0] st, input logic [4:0] fl, input logic [4:0] ex,
                     input logic [19:0] len, input logic [4:0] k, input logic [4:0] d,
                     input logic [4:0] b);
        step(1'b0, st, fl, ex, len, 1'b0, k, d, b, 4'd0, 4'd0, 4'd0, 1'b0);
    endtask

    // monitor
    initial begin
        logic [W-1:0] got, e, m;
        int t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                got = {keep, dirty, busy, stall_cnt, flush_cnt, bubble_cnt};
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if ((got & m) !== (e & m)) begin
                    errors++;
                    $display("FAIL step%0d keep_dirty_busy_cnt got %h required %h (mask %h)",
                             t, got, e, m);
                end
            end
        end
    end

    initial begin
        logic [4:0] d;
        logic [3:0] sc, bc;
        rst = 1'b1; stall = '0; flush = '0; extend = '0; ext_len = '0; perf_clr = 1'b0;

        // reset state, then fill
        step(1'b1, 5'b0, 5'b0, 5'b0, 20'h0, 1'b0, 5'b00000, 5'b11111, 5'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        rst = 1'b0;
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b01111, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00111, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00011, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00001, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00000, 5'b0);

        // one-cycle stall of stage 3; extend on the resulting bubble is ignored
        s(5'b01000, 5'b0, 5'b0, 20'h0, 5'b11000, 5'b00000, 5'b0);
        s(5'b0, 5'b0, 5'b00100, 20'h00300, 5'b00000, 5'b00100, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00010, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00001, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00000, 5'b0);

        // extend stage 2 by 3; re-pulse while running is ignored
        s(5'b0, 5'b0, 5'b00100, 20'h00300, 5'b11100, 5'b00000, 5'b00000);
        s(5'b0, 5'b0, 5'b00100, 20'h00300, 5'b11100, 5'b00010, 5'b00100);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b11100, 5'b00011, 5'b00100);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00011, 5'b00000);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00001, 5'b00000);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00000, 5'b00000);

        // extend by 2 overlapped with a stall: counter still runs down
        s(5'b0, 5'b0, 5'b00100, 20'h00200, 5'b11100, 5'b00000, 5'b00000);
        s(5'b00100, 5'b0, 5'b0, 20'h0, 5'b11100, 5'b00010, 5'b00100);
        s(5'b00100, 5'b0, 5'b0, 20'h0, 5'b11100, 5'b00011, 5'b00000);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00011, 5'b00000);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00001, 5'b00000);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00000, 5'b00000);

        // flush stages 4,3 while stage 1 stalls
        s(5'b00010, 5'b11000, 5'b0, 20'h0, 5'b11110, 5'b00000, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b11001, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b01100, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00110, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00011, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00001, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00000, 5'b0);

        // zero-length extend is ignored
        s(5'b0, 5'b0, 5'b00010, 20'h0, 5'b00000, 5'b00000, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00000, 5'b0);

        // reset in the middle of a 5-cycle extend
        s(5'b0, 5'b0, 5'b00100, 20'h00500, 5'b11100, 5'b00000, 5'b00000);
        step(1'b1, 5'b0, 5'b0, 5'b0, 20'h0, 1'b0, 5'b00000, 5'b11111, 5'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b11111, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b01111, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00111, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00011, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00001, 5'b0);
        s(5'b0, 5'b0, 5'b0, 20'h0, 5'b00000, 5'b00000, 5'b0);

        // performance counters: clear, 20 fetch stalls, clear with flush, count flush
        step(1'b0, 5'b0, 5'b0, 5'b0, 20'h0, 1'b1, 5'b00000, 5'b00000, 5'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            case (k)
                1:       d = 5'b00000;
                2:       d = 5'b01000;
                3:       d = 5'b01100;
                4:       d = 5'b01110;
                default: d = 5'b01111;
            endcase
            sc = PERF ? ((k - 1 > 15) ? 4'd15 : 4'(k - 1)) : 4'd0;
            bc = (PERF && k >= 5) ? 4'(k - 5) : 4'd0;
            step(1'b0, 5'b10000, 5'b0, 5'b0, 20'h0, 1'b0, 5'b10000, d, 5'b0, sc, 4'd0, bc, 1'b1);
        end
        step(1'b0, 5'b0, 5'b00001, 5'b0, 20'h0, 1'b1, 5'b00000, 5'b01111, 5'b0,
             PERF ? 4'd15 : 4'd0, 4'd0, PERF ? 4'd15 : 4'd0, 1'b1);
        step(1'b0, 5'b0, 5'b00001, 5'b0, 20'h0, 1'b0, 5'b00000, 5'b00111, 5'b0,
             4'd0, 4'd0, 4'd0, 1'b1);
        step(1'b0, 5'b0, 5'b0, 5'b0, 20'h0, 1'b0, 5'b00000, 5'b00011, 5'b0,
             4'd0, PERF ? 4'd1 : 4'd0, PERF ? 4'd1 : 4'd0, 1'b1);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d required 0", exp_q.size());
        end

        // report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
